// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver: tear-free frame latch, blink, leading-zero blanking, dead time.
// Optional decimal-point path enabled by defining SEG_DP_EN.
module seg_scan_display #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEAD_CYCLES    = 50,
    parameter int unsigned BLINK_DIV      = 125,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk_50mhz,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lzb_en,
`ifdef SEG_DP_EN
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic                      seg_dp,
`endif
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     key0,
    output logic                      frame_start
);

    localparam int unsigned CntW  = $clog2(SCAN_DIV);
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FcntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    // XOR masks that map active-high internal values onto pin polarity.
    localparam logic [6:0]            SegOff = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DigOff = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} :
                                                                       {NUM_DIGITS{1'b0}};

    logic [CntW-1:0]         cnt_q;
    logic [IdxW-1:0]         idx_q;
    logic [4*NUM_DIGITS-1:0] frame_q;
    logic [FcntW-1:0]        fcnt_q;
    logic                    blink_q;

    logic                    tick, last_digit, dead, blink_off, blank, all_zero;
    logic [3:0]              nib;
    logic [6:0]              glyph, seg_on;
    logic [NUM_DIGITS-1:0]   onehot, key_on, lead_zero;

    assign tick       = (cnt_q == CntW'(SCAN_DIV - 1));
    assign last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));
    assign dead       = (cnt_q < CntW'(DEAD_CYCLES));
    assign blink_off  = blink_mask[idx_q] && blink_q;
    assign onehot     = NUM_DIGITS'(1) << idx_q;
    assign key_on     = dead ? '0 : onehot;

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) nib = frame_q[4*i +: 4];
        end
    end

    // lead_zero[i]: nibbles i..top are all zero; digit 0 is never a leading zero.
    always_comb begin
        lead_zero = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero     = all_zero && (frame_q[4*i +: 4] == 4'h0);
            lead_zero[i] = all_zero;
        end
    end

    always_comb begin
        unique case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    end

    assign blank  = dead || blink_off || (lzb_en && lead_zero[idx_q]);
    assign seg_on = blank ? 7'h00 : glyph;

`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0] dp_frame_q;
    logic                  dp_on;

    assign dp_on = !(dead || blink_off) && dp_frame_q[idx_q];

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            dp_frame_q <= '0;
            seg_dp     <= SegOff[0];
        end else begin
            if (tick && last_digit) dp_frame_q <= dp_mask;
            seg_dp <= dp_on ^ SegOff[0];
        end
    end
`endif

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            fcnt_q      <= '0;
            blink_q     <= 1'b0;
            seg         <= SegOff;
            key0        <= DigOff;
            frame_start <= 1'b0;
        end else begin
            cnt_q       <= tick ? '0 : cnt_q + 1'b1;
            frame_start <= tick && last_digit;
            if (tick) begin
                idx_q <= last_digit ? '0 : idx_q + 1'b1;
                if (last_digit) begin
                    frame_q <= digits;
                    if (fcnt_q == FcntW'(BLINK_DIV - 1)) begin
                        fcnt_q  <= '0;
                        blink_q <= ~blink_q;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
            end
            seg  <= seg_on ^ SegOff;
            key0 <= key_on ^ DigOff;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: random and directed stimulus against a cycle-count based model.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int DC = 1;
    localparam int BD = 2;
    localparam int FL = ND * SD;

    logic            clk_50mhz = 1'b0;
    logic            rst;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   blink_mask;
    logic            lzb_en;
    logic [6:0]      seg;
    logic [ND-1:0]   key0;
    logic            frame_start;
`ifdef SEG_DP_EN
    logic [ND-1:0]   dp_mask;
    logic            seg_dp;
`endif

    seg_scan_display #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_DIV(BD),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .digits     (digits),
        .blink_mask (blink_mask),
        .lzb_en     (lzb_en),
`ifdef SEG_DP_EN
        .dp_mask    (dp_mask),
        .seg_dp     (seg_dp),
`endif
        .seg        (seg),
        .key0       (key0),
        .frame_start(frame_start)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    int checks = 0;
    int errors = 0;
    int n;                      // edges since reset release
    logic [4*ND-1:0] m_frame;
    logic [ND-1:0]   m_dp;
    logic [6:0]      glyph [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        @(posedge clk_50mhz);
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_key0", 32'(key0), 32'hF);
        chk("rst_fs", 32'(frame_start), 32'h0);
`ifdef SEG_DP_EN
        chk("rst_dp", 32'(seg_dp), 32'h1);
`endif
        n       = 0;
        m_frame = '0;
        m_dp    = '0;
    endtask

    // One clock: expected outputs follow from the position in the scan and the latched frame.
    task automatic step();
        int cnt, idx, f;
        logic ph, dead, lz, blank, e_fs;
        logic [3:0] nib;
        logic [6:0] e_seg;
        logic [ND-1:0] e_key;
        logic [4*ND-1:0] next_frame;
        cnt  = n % SD;
        idx  = (n / SD) % ND;
        f    = n / FL;
        ph   = ((f / BD) % 2) == 1;
        dead = cnt < DC;
        nib  = m_frame[4*idx +: 4];
        lz   = lzb_en && (idx != 0) && ((m_frame >> (4*idx)) == 0);
        blank = dead || (blink_mask[idx] && ph) || lz;
        e_seg = blank ? 7'h7F : ~glyph[nib];
        e_key = dead ? {ND{1'b1}} : ~(ND'(1) << idx);
        e_fs  = (n % FL) == FL - 1;
        next_frame = digits;
`ifdef SEG_DP_EN
        begin
            logic e_dp;
            logic [ND-1:0] next_dp;
            e_dp    = !(dead || (blink_mask[idx] && ph)) && m_dp[idx];
            next_dp = dp_mask;
            @(posedge clk_50mhz);
            #1;
            chk("seg_dp", 32'(seg_dp), 32'(!e_dp));
            if (e_fs) m_dp = next_dp;
        end
`else
        @(posedge clk_50mhz);
        #1;
`endif
        chk("seg", 32'(seg), 32'(e_seg));
        chk("key0", 32'(key0), 32'(e_key));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        if (e_fs) m_frame = next_frame;
        n++;
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        digits = '0; blink_mask = '0; lzb_en = 1'b0; n = 0;
        m_frame = '0; m_dp = '0;
`ifdef SEG_DP_EN
        dp_mask = 4'b0100;
`endif
        for (int k = 0; k < 3; k++) reset_cycle();
        rst = 1'b0;

        // First frame shows zeros; mid-frame digit change waits for the latch.
        run(5);
        digits = 16'h1234;
        run(3 * FL - 5);

        digits = 16'h0050; lzb_en = 1'b1;
        run(2 * FL);
        lzb_en = 1'b0;
        run(2 * FL);

        blink_mask = 4'b0001;
        run(5 * FL);
        blink_mask = 4'b0000;

        // Random stimulus with frequent leading zeros.
        for (int k = 0; k < 30 * FL; k++) begin
            if ($urandom_range(0, 7) == 0) digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 11) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 11) == 0) lzb_en = 1'($urandom);
`ifdef SEG_DP_EN
            if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom);
`endif
            step();
        end

        // Reset pulse while idx=2, cnt=2.
        for (int k = 0; k < FL; k++) begin
            if (((n / SD) % ND) == 2 && (n % SD) == 2) break;
            step();
        end
        chk("pre_rst_pos", 32'(((n / SD) % ND) * 16 + (n % SD)), 32'h22);
        reset_cycle();
        rst = 1'b0;
        digits = 16'hA7C0; lzb_en = 1'b1;
        run(4 * FL);

        for (int k = 0; k < 10 * FL; k++) begin
            if ($urandom_range(0, 5) == 0) digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) blink_mask = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
